// File: rtl/cache_set_if.sv
// Request/response bus between a requester and the cache set controller.
interface cache_set_if #(
    parameter int TAG_W = 8
);
    localparam int DATA_W = 16;

    logic              req_valid;
    logic              req_write;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_tag, req_data,
        input  req_ready, resp_valid, resp_hit, resp_err, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_tag, req_data,
        output req_ready, resp_valid, resp_hit, resp_err, resp_data
    );
endinterface

// File: rtl/cache_set_ctrl.sv
// Sequencing controller for one cache set: tag lookup, victim selection and the
// enable/ack handshake to the per-way 16-bit storage blocks.
module cache_set_ctrl #(
    parameter int WAYS        = 2,
    parameter int TAG_W       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_set_if.slave           bus,
    output logic [WAYS-1:0]      blk_enable,
    output logic                 blk_write,
    output logic [15:0]          blk_data_in,
    input  logic [16*WAYS-1:0]   blk_data_out,
    input  logic [WAYS-1:0]      blk_ack
);
    localparam int DATA_W = 16;
    localparam int IW     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW     = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_ACK, RESP} state_t;

    state_t state, state_nxt;

    logic [WAYS-1:0]   valid;
    logic [TAG_W-1:0]  tags [WAYS];
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     cnt;

    logic              wr_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IW-1:0]     way_q;
    logic              hit_q;
    logic              vict_q;
    logic              err_q;

    logic              match_found;
    logic              inv_found;
    logic [IW-1:0]     match_way;
    logic [IW-1:0]     inv_way;
    logic              ack_sel;
    logic [DATA_W-1:0] rd_sel;
    logic              timeout;

    // Descending scan so the lowest-index candidate is the one that sticks.
    always_comb begin
        match_found = 1'b0;
        inv_found   = 1'b0;
        match_way   = '0;
        inv_way     = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == tag_q)) begin
                match_found = 1'b1;
                match_way   = IW'(i);
            end
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_way   = IW'(i);
            end
        end
    end

    assign ack_sel = blk_ack[way_q];
    assign rd_sel  = blk_data_out[way_q*DATA_W +: DATA_W];
    assign timeout = (cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_data  = '0;
        blk_enable     = '0;
        blk_write      = 1'b0;
        blk_data_in    = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!wr_q && !match_found) begin
                    state_nxt = RESP;
                end else begin
                    // Setup cycle: strobe and data settle before the enable rises.
                    blk_write   = wr_q;
                    blk_data_in = wr_q ? wdata_q : '0;
                    state_nxt   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                blk_enable[way_q] = 1'b1;
                blk_write         = wr_q;
                blk_data_in       = wr_q ? wdata_q : '0;
                if (ack_sel || timeout) state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit_q;
                bus.resp_err   = err_q;
                bus.resp_data  = rdata_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            wr_q   <= 1'b0;
            way_q  <= '0;
            hit_q  <= 1'b0;
            vict_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < WAYS; i++) tags[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        tag_q   <= bus.req_tag;
                        wdata_q <= bus.req_data;
                    end
                end
                ACCESS: begin
                    hit_q   <= match_found;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    cnt     <= '0;
                    vict_q  <= !match_found && !inv_found;
                    if (match_found)    way_q <= match_way;
                    else if (inv_found) way_q <= inv_way;
                    else                way_q <= ptr;
                end
                WAIT_ACK: begin
                    if (ack_sel) begin
                        if (!wr_q) rdata_q <= rd_sel;
                        if (wr_q && !hit_q) begin
                            tags[way_q]  <= tag_q;
                            valid[way_q] <= 1'b1;
                            if (vict_q) ptr <= (ptr == IW'(WAYS - 1)) ? '0 : ptr + 1'b1;
                        end
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: cnt <= '0;
                default: ;
            endcase
        end
    end
endmodule
